// File: rtl/cipher_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cipher_round_ctrl
// Brief    : Iterative 8-bit toy round cipher controller (IDLE/RUN/DONE FSM),
//            one round per clock. Optional abort input: CIPHER_ROUND_CTRL_ABORT_EN.
// Revision : 1.0
// ============================================================================
module cipher_round_ctrl #(
    parameter int LAST_ROUND = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] in_key,
    input  logic [7:0] data_in,
`ifdef CIPHER_ROUND_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic [3:0] round_idx,
    output logic [7:0] round_key
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
    localparam logic [3:0] c_last    = 4'(LAST_ROUND);

    logic [1:0] r_state;
    logic       r_mode;
    logic [7:0] r_key;
    logic [7:0] r_data;
    logic [3:0] r_round;
    logic [7:0] r_data_out;

    logic [7:0] w_key;
    logic [7:0] w_mixed;
    logic [7:0] w_enc;
    logic [7:0] w_dec;
    logic [7:0] w_result;
    logic       w_last;
    logic       w_abort;
    logic       w_run;

    function automatic logic [7:0] f_round_key(input logic [7:0] k, input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd0:    v = k;
            4'd1:    v = {k[6:0], k[7]};
            4'd2:    v = k ^ 8'hAA;
            4'd3:    v = {k[0], k[7:1]};
            4'd4:    v = ~k;
            4'd5:    v = k + 8'h1F;
            4'd6:    v = k - 8'h1F;
            4'd7:    v = {k[3:0], k[7:4]};
            4'd8:    v = k ^ 8'h55;
            4'd9:    v = {k[5:0], k[7:6]};
            4'd10:   v = {k[6:0], k[7]};
            default: v = k;
        endcase
        return v;
    endfunction

    assign w_key    = f_round_key(r_key, r_round);
    assign w_mixed  = r_data ^ w_key;
    // Decrypt round is the exact inverse of the encrypt round for the same key.
    assign w_enc    = {w_mixed[6:0], w_mixed[7]};
    assign w_dec    = {r_data[0], r_data[7:1]} ^ w_key;
    assign w_result = r_mode ? w_dec : w_enc;
    assign w_last   = r_mode ? (r_round == 4'd0) : (r_round == c_last);
    assign w_run    = (r_state == c_st_run);

`ifdef CIPHER_ROUND_CTRL_ABORT_EN
    assign w_abort  = abort;
`else
    assign w_abort  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_mode     <= 1'b0;
            r_key      <= 8'h00;
            r_data     <= 8'h00;
            r_round    <= 4'd0;
            r_data_out <= 8'h00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_key   <= in_key;
                        r_data  <= data_in;
                        r_round <= mode ? c_last : 4'd0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_abort) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_data <= w_result;
                        if (w_last) begin
                            r_data_out <= w_result;
                            r_state    <= c_st_done;
                        end else begin
                            r_round <= r_mode ? (r_round - 4'd1) : (r_round + 4'd1);
                        end
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign busy      = w_run;
    assign done      = (r_state == c_st_done);
    assign data_out  = r_data_out;
    assign round_idx = w_run ? r_round : 4'd0;
    assign round_key = w_run ? w_key : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_cipher_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_round_ctrl
// Brief    : Self-checking bench: directed vector table, round-trip sweep,
//            protocol, reset and (when enabled) abort sequences.
// Revision : 1.0
// ============================================================================
module tb_cipher_round_ctrl;

    localparam int LR = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] in_key;
    logic [7:0] data_in;
`ifdef CIPHER_ROUND_CTRL_ABORT_EN
    logic       abort;
`endif
    logic       busy;
    logic       done;
    logic [7:0] data_out;
    logic [3:0] round_idx;
    logic [7:0] round_key;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cipher_round_ctrl #(.LAST_ROUND(LR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_key    (in_key),
        .data_in   (data_in),
`ifdef CIPHER_ROUND_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .round_idx (round_idx),
        .round_key (round_key)
    );

    typedef struct {
        logic       m;
        logic [7:0] k;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [7:0] rk(input logic [7:0] k, input int r);
        case (r)
            0:       return k;
            1:       return {k[6:0], k[7]};
            2:       return k ^ 8'hAA;
            3:       return {k[0], k[7:1]};
            4:       return ~k;
            5:       return k + 8'h1F;
            6:       return k - 8'h1F;
            7:       return {k[3:0], k[7:4]};
            8:       return k ^ 8'h55;
            9:       return {k[5:0], k[7:6]};
            default: return {k[6:0], k[7]};
        endcase
    endfunction

    function automatic logic [7:0] enc_model(input logic [7:0] k, input logic [7:0] d);
        logic [7:0] s;
        logic [7:0] t;
        s = d;
        for (int r = 0; r <= LR; r++) begin
            t = s ^ rk(k, r);
            s = {t[6:0], t[7]};
        end
        return s;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Runs one operation from IDLE; returns in IDLE one cycle after done.
    task automatic do_op(input logic m, input logic [7:0] k, input logic [7:0] d,
                         output logic [7:0] res, output int lat, output int trace_err);
        int exp_idx;
        trace_err = 0;
        lat = -1;
        @(negedge clk);
        start = 1'b1; mode = m; in_key = k; data_in = d;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; in_key = ~k; data_in = d ^ 8'hC3;
        for (int n = 0; n < 30; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            exp_idx = m ? (LR - n) : n;
            if (!busy || round_idx !== 4'(exp_idx) || round_key !== rk(k, exp_idx))
                trace_err++;
            @(posedge clk); #1;
        end
        res = data_out;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        logic [7:0] res, res2, k, d, prev;
        int lat, lat2, te, te2, n, bad;

        rst = 1'b1; start = 1'b0; mode = 1'b0; in_key = 8'h00; data_in = 8'h00;
`ifdef CIPHER_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        vecs[0] = '{1'b0, 8'h00, 8'h00, 8'hFB};
        vecs[1] = '{1'b1, 8'h00, 8'hFB, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 8'hFF, 8'h04};
        vecs[3] = '{1'b1, 8'h00, 8'h04, 8'hFF};

        repeat (2) @(posedge clk);
        #1;
        check8("reset_busy", {7'd0, busy}, 8'h00);
        check8("reset_done", {7'd0, done}, 8'h00);
        check8("reset_data_out", data_out, 8'h00);
        check8("reset_round_idx", {4'd0, round_idx}, 8'h00);
        check8("reset_round_key", round_key, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].m, vecs[i].k, vecs[i].d, res, lat, te);
            check8($sformatf("vec%0d_data_out", i), res, vecs[i].exp);
            check_int($sformatf("vec%0d_latency", i), lat, LR + 1);
            check_int($sformatf("vec%0d_trace", i), te, 0);
            check8($sformatf("vec%0d_idle_after", i), {6'd0, busy, done}, 8'h00);
        end

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            k = 8'($urandom);
            d = 8'($urandom);
            do_op(1'b0, k, d, res, lat, te);
            do_op(1'b1, k, res, res2, lat2, te2);
            check8("rt_encrypt", res, enc_model(k, d));
            check8("rt_decrypt", res2, d);
            check_int("rt_trace", te + te2, 0);
            if (lat != LR + 1 || lat2 != LR + 1) bad++;
        end
        check_int("rt_latency_errors", bad, 0);

        // start pulsed in RUN and in DONE must not be honoured or queued
        @(negedge clk);
        start = 1'b1; mode = 1'b0; in_key = 8'h3C; data_in = 8'h81;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        start = 1'b1; in_key = 8'hFF; data_in = 8'h00; mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check8("ign_done_seen", {7'd0, done}, 8'h01);
        check8("ign_data_out", data_out, enc_model(8'h3C, 8'h81));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check8("ign_done_width", {6'd0, busy, done}, 8'h00);
        @(posedge clk); #1;
        check8("ign_not_queued", {6'd0, busy, done}, 8'h00);

        // start held high: back-to-back with one IDLE cycle
        @(negedge clk);
        start = 1'b1; mode = 1'b0; in_key = 8'hA5; data_in = 8'h5A;
        wait_done(n);
        check8("held_first_done", {7'd0, done}, 8'h01);
        check8("held_first_data", data_out, enc_model(8'hA5, 8'h5A));
        @(posedge clk); #1;
        check8("held_gap_idle", {6'd0, busy, done}, 8'h00);
        @(posedge clk); #1;
        check8("held_restart", {6'd0, busy, done}, 8'h02);
        check8("held_restart_idx", {4'd0, round_idx}, 8'h00);
        start = 1'b0;
        wait_done(n);
        check_int("held_second_latency", n, LR + 1);
        check8("held_second_data", data_out, enc_model(8'hA5, 8'h5A));
        @(posedge clk); #1;

        // asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; mode = 1'b0; in_key = 8'h00; data_in = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #3 rst = 1'b1;
        #1;
        check8("arst_busy", {7'd0, busy}, 8'h00);
        check8("arst_done", {7'd0, done}, 8'h00);
        check8("arst_data_out", data_out, 8'h00);
        check8("arst_round_idx", {4'd0, round_idx}, 8'h00);
        check8("arst_round_key", round_key, 8'h00);
        @(posedge clk); #2;
        rst = 1'b0;
        bad = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        check_int("arst_no_done", bad, 0);

`ifdef CIPHER_ROUND_CTRL_ABORT_EN
        do_op(1'b0, 8'h12, 8'h34, res, lat, te);
        prev = data_out;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; in_key = 8'h77; data_in = 8'h99;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check8("abort_reached_r5", {4'd0, round_idx}, 8'h05);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check8("abort_idle", {6'd0, busy, done}, 8'h00);
        check8("abort_data_kept", data_out, prev);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        check_int("abort_no_done", bad, 0);
`else
        prev = 8'h00;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cipher_round_ctrl.md
CIPHER_ROUND_CTRL -- requirements
Module: cipher_round_ctrl

Interface
REQ-001 Parameter: LAST_ROUND, default 10, index of the final round key used; legal range 1..10.
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Port: mode  input  1  0 = encrypt, 1 = decrypt; captured with start.
REQ-006 Port: in_key  input  8  cipher key; captured with start.
REQ-007 Port: data_in  input  8  plaintext or ciphertext; captured with start.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: data_out  output  8  registered result; holds its value until the next completion.
REQ-011 Port: round_idx  output  4  index of the round currently executing; 0 outside RUN.
REQ-012 Port: round_key  output  8  key applied in the current round; 0 outside RUN.

Function
REQ-013 Round key r (from captured key K, all arithmetic mod 256):
- r0 = K
- r1 = rotl1(K)
- r2 = K^AA
- r3 = rotr1(K)
- r4 = ~K
- r5 = K+1F
- r6 = K-1F
- r7 = nibble swap
- r8 = K^55
- r9 = rotl2(K)
- r10 = rotl1(K)
REQ-014 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE with start=1: capture K, data, mode; set round_idx to 0 (encrypt) or LAST_ROUND (decrypt); go to RUN.
REQ-016 RUN, encrypt, one round per cycle: state <= rotl1(state ^ key[round_idx]); round_idx increments.
REQ-017 RUN, decrypt, one round per cycle: state <= rotr1(state) ^ key[round_idx]; round_idx decrements.
REQ-018 Last-round edge (round_idx = LAST_ROUND for encrypt, 0 for decrypt): load data_out with the round result; go to DONE.
REQ-019 DONE: done=1 for exactly one cycle; next edge returns to IDLE.
REQ-020 Latency: done is high in the cycle following the (LAST_ROUND+1)th clock edge after the start-sampling edge.
REQ-021 start while in RUN or DONE is ignored; it is not queued.
REQ-022 start held high continuously: a new operation begins on the first IDLE edge after DONE; there is one idle cycle between operations.
REQ-023 Input changes during RUN do not affect the operation in progress.
REQ-024 Decrypt(Encrypt(D, K), K) equals D for every D, K and LAST_ROUND.

Reset
REQ-025 rst=1 immediately forces IDLE, independent of clk.
REQ-026 Reset values: busy=0, done=0, data_out=00, round_idx=0, round_key=00; internal state and key registers are 00.
REQ-027 Reset during RUN or DONE abandons the operation; no done pulse is produced.

Configuration
REQ-028 Macro CIPHER_ROUND_CTRL_ABORT_EN defined: add input port abort (1 bit).
- In RUN, abort=1 returns the FSM to IDLE on the next edge.
- No done pulse; data_out is unchanged.
- abort is ignored in IDLE and DONE.
- abort has priority over round completion.
REQ-029 Macro undefined: the abort port is absent, and every RUN operation completes.

Verification
REQ-030 Reset, LAST_ROUND=10: assert rst mid-operation -> all outputs 0 asynchronously; no done pulse afterwards.
REQ-031 Encrypt: K=00, data_in=00, mode=0 -> done 11 edges after start; data_out=FB.
REQ-032 Decrypt: K=00, data_in=FB, mode=1 -> data_out=00; round_idx sequence 10,9,...,0.
REQ-033 Round-trip: random K and D, encrypt then decrypt (1000 pairs) -> recovers D; round_key trace matches REQ-013 at every RUN cycle.
REQ-034 Protocol: start pulsed during RUN -> ignored. start held high -> back-to-back operations with exactly one IDLE cycle between them; done width is 1 cycle.
REQ-035 With CIPHER_ROUND_CTRL_ABORT_EN defined: abort at round 5 -> IDLE next edge; busy=0; no done; data_out keeps its previous value.
